// File: rtl/pixel_readout_ctrl.sv
// Row-by-row readout sequencer for the shared pixel data bus, feeding a small valid/ready output FIFO.
// Optional build macro PIXEL_READOUT_GRAY_DECODE_EN gray-decodes each 8-bit lane before the FIFO push.
module pixel_readout_ctrl #(
  parameter int N_ROWS     = 2,
  parameter int DATA_W     = 16,
  parameter int SETTLE     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  output logic [N_ROWS-1:0]             rd_en,
  input  logic [DATA_W-1:0]             pix_bus,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N_ROWS - 1);

  typedef enum logic [1:0] {IDLE, SELECT, DONE} state_t;

  state_t            state, state_nxt;
  logic [ROW_W-1:0]  row, row_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              sample_pt;
  logic              fifo_full;
  logic              push_vld_p0;
  logic [DATA_W-1:0] push_word_p0;
  logic              pop;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];

`ifdef PIXEL_READOUT_GRAY_DECODE_EN
  localparam int LANES = DATA_W / 8;

  function automatic logic [DATA_W-1:0] gray_decode(input logic [DATA_W-1:0] g);
    logic [DATA_W-1:0] b;
    b = '0;
    for (int l = 0; l < LANES; l++) begin
      b[l*8+7] = g[l*8+7];
      for (int i = 6; i >= 0; i--) b[l*8+i] = b[l*8+i+1] ^ g[l*8+i];
    end
    return b;
  endfunction

  assign push_word_p0 = gray_decode(pix_bus);
`else
  assign push_word_p0 = pix_bus;
`endif

  assign sample_pt   = (state == SELECT) && (cnt == CNT_LAST);
  // Full is judged on pre-pop occupancy, so a same-cycle pop never frees a slot for the push.
  assign fifo_full   = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign push_vld_p0 = sample_pt && !fifo_full;
  assign pop         = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      row   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      row   <= row_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SELECT;
          row_nxt   = '0;
          cnt_nxt   = '0;
        end
      end
      SELECT: begin
        if (cnt != CNT_LAST) begin
          cnt_nxt = cnt + CNT_W'(1);
        end else if (!fifo_full) begin
          if (row != ROW_LAST) begin
            row_nxt = row + ROW_W'(1);
            cnt_nxt = '0;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        row_nxt   = '0;
        cnt_nxt   = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_en = '0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      SELECT: begin
        rd_en = N_ROWS'(1) << row;
        busy  = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Stage p0 -> FIFO: sampled bus word is registered into storage on the push edge.
  always_ff @(posedge clk) begin
    if (push_vld_p0) mem[wr_ptr] <= push_word_p0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push_vld_p0) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)         rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_level <= fifo_level + LVL_W'(push_vld_p0) - LVL_W'(pop);
    end
  end

  assign out_valid = (fifo_level != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// Directed bench for pixel_readout_ctrl: a 2-row instance driven from a vector table,
// and a 6-row instance for FIFO stall, start-while-busy and drain ordering.
module tb_pixel_readout_ctrl;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 2-row instance
  logic        reset2, start2, rdy2, valid2, busy2, done2;
  logic [1:0]  rd_en2;
  logic [15:0] pix2, data2;
  logic [2:0]  level2;

  // 6-row instance
  logic        reset6, start6, rdy6, valid6, busy6, done6;
  logic [5:0]  rd_en6;
  logic [15:0] pix6, data6;
  logic [2:0]  level6;

  pixel_readout_ctrl #(.N_ROWS(2), .DATA_W(16), .SETTLE(2), .FIFO_DEPTH(4)) u_dut2 (
    .clk(clk), .reset(reset2), .start(start2), .rd_en(rd_en2), .pix_bus(pix2),
    .out_data(data2), .out_valid(valid2), .out_ready(rdy2), .busy(busy2),
    .done(done2), .fifo_level(level2));

  pixel_readout_ctrl #(.N_ROWS(6), .DATA_W(16), .SETTLE(2), .FIFO_DEPTH(4)) u_dut6 (
    .clk(clk), .reset(reset6), .start(start6), .rd_en(rd_en6), .pix_bus(pix6),
    .out_data(data6), .out_valid(valid6), .out_ready(rdy6), .busy(busy6),
    .done(done6), .fifo_level(level6));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(input logic [15:0] w);
`ifdef PIXEL_READOUT_GRAY_DECODE_EN
    logic [15:0] b;
    logic [7:0]  lane;
    for (int l = 0; l < 2; l++) begin
      lane = w[l*8 +: 8];
      for (int i = 0; i < 8; i++) b[l*8+i] = ^(lane >> i);
    end
    return b;
`else
    return w;
`endif
  endfunction

  function automatic logic [15:0] row_word(input int r);
    return 16'h3C10 + 16'(r) * 16'h0123;
  endfunction

  // Pixel array model for the 6-row instance: the selected row drives the bus.
  always_comb begin
    pix6 = 16'hDEAD;
    for (int r = 0; r < 6; r++) if (rd_en6[r]) pix6 = row_word(r);
  end

  logic [15:0] q6[$];
  int done_cnt6 = 0;
  int done_cnt2 = 0;
  always @(posedge clk) begin
    if (valid6 && rdy6) q6.push_back(data6);
    if (done6) done_cnt6++;
    if (done2) done_cnt2++;
  end

  typedef struct {
    logic        start;
    logic [15:0] pix;
    logic        rdy;
    logic [1:0]  rd_en;
    logic        busy;
    logic        done;
    logic        valid;
    logic [15:0] data;
    logic [2:0]  level;
  } vec_t;

  vec_t tbl[15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, snap, n;
    tbl[0]  = '{1'b1, 16'h0000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0};
    tbl[1]  = '{1'b0, 16'h1234, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0};
    tbl[2]  = '{1'b0, 16'h1234, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0};
    tbl[3]  = '{1'b0, 16'h5678, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, exp_word(16'h1234), 3'd1};
    tbl[4]  = '{1'b0, 16'h5678, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0};
    tbl[5]  = '{1'b0, 16'h0000, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, exp_word(16'h5678), 3'd1};
    tbl[6]  = '{1'b0, 16'h0000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0};
    tbl[7]  = '{1'b1, 16'h0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0};
    tbl[8]  = '{1'b0, 16'hAAAA, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0};
    tbl[9]  = '{1'b0, 16'hAAAA, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0};
    tbl[10] = '{1'b0, 16'h5555, 1'b0, 2'b10, 1'b1, 1'b0, 1'b1, exp_word(16'hAAAA), 3'd1};
    tbl[11] = '{1'b1, 16'h5555, 1'b0, 2'b10, 1'b1, 1'b0, 1'b1, exp_word(16'hAAAA), 3'd1};
    tbl[12] = '{1'b1, 16'h0000, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, exp_word(16'hAAAA), 3'd2};
    tbl[13] = '{1'b0, 16'h0000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, exp_word(16'h5555), 3'd1};
    tbl[14] = '{1'b0, 16'h0000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0};

    reset2 = 1'b1; start2 = 1'b0; rdy2 = 1'b1; pix2 = '0;
    reset6 = 1'b1; start6 = 1'b0; rdy6 = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("reset_state2", {rd_en2, busy2, done2, valid2, data2, level2}, 64'h0);
    chk("reset_state6", {rd_en6, busy6, done6, valid6, data6, level6}, 64'h0);
    tick();
    reset2 = 1'b0;
    reset6 = 1'b0;

    // Two frames on the 2-row instance, one per table half.
    for (int k = 0; k < 15; k++) begin
      start2 = tbl[k].start;
      pix2   = tbl[k].pix;
      rdy2   = tbl[k].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d", k), {rd_en2, busy2, done2, valid2, data2, level2},
          {tbl[k].rd_en, tbl[k].busy, tbl[k].done, tbl[k].valid, tbl[k].data, tbl[k].level});
      tick();
    end
    start2 = 1'b0;

    // Stall on the 6-row instance with out_ready low.
    base = q6.size();
    snap = done_cnt6;
    rdy6 = 1'b0;
    start6 = 1'b1;
    tick();
    start6 = 1'b0;
    repeat (14) tick();
    @(negedge clk);
    chk("stall_rd_en", rd_en6, 6'b010000);
    chk("stall_level", level6, 3'd4);
    chk("stall_head", {valid6, busy6, data6}, {1'b1, 1'b1, exp_word(row_word(0))});
    rdy6 = 1'b1;
    tick();
    @(negedge clk);
    chk("fullpop_level", level6, 3'd3);
    chk("fullpop_rd_en", rd_en6, 6'b010000);
    chk("fullpop_head", data6, exp_word(row_word(1)));
    tick();
    @(negedge clk);
    chk("resume_rd_en", rd_en6, 6'b100000);
    chk("resume_level", level6, 3'd3);
    n = 0;
    while (!(valid6 == 1'b0 && busy6 == 1'b0) && n < 40) begin
      tick();
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", (n < 40), 1'b1);
    chk("stall_word_count", q6.size() - base, 6);
    for (int r = 0; r < 6; r++)
      if (base + r < q6.size())
        chk($sformatf("stall_word%0d", r), q6[base + r], exp_word(row_word(r)));
    chk("stall_done_count", done_cnt6 - snap, 1);

    // start held high through a whole frame is honoured once.
    tick();
    base = q6.size();
    snap = done_cnt6;
    start6 = 1'b1;
    repeat (13) tick();
    start6 = 1'b0;
    @(negedge clk);
    chk("frame_end_done", {busy6, done6}, 2'b11);
    tick();
    @(negedge clk);
    chk("frame_end_idle", {busy6, done6}, 2'b00);
    repeat (6) tick();
    @(negedge clk);
    chk("ignore_push_count", q6.size() - base, 6);
    chk("ignore_done_count", done_cnt6 - snap, 1);
    if (q6.size() - base == 6)
      chk("ignore_last_word", q6[base + 5], exp_word(row_word(5)));

    // Reset during row 1 SELECT discards the frame and the FIFO.
    tick();
    rdy2 = 1'b0;
    pix2 = 16'h1234;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick();
    pix2 = 16'h5678;
    tick();
    @(negedge clk);
    chk("midreset_pre", {rd_en2, level2}, {2'b10, 3'd1});
    snap = done_cnt2;
    reset2 = 1'b1;
    tick();
    reset2 = 1'b0;
    @(negedge clk);
    chk("midreset_post", {rd_en2, busy2, done2, valid2, data2, level2}, 64'h0);
    repeat (4) tick();
    @(negedge clk);
    chk("midreset_no_done", done_cnt2 - snap, 0);
    chk("midreset_idle", {busy2, valid2}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
